// File: rtl/msg_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART TX between host and player messages.
// Optional feature macro MSG_CHECKSUM_EN appends an XOR checksum byte to every message.
module msg_tx_arbiter #(
  parameter int unsigned MAX_BYTES      = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic                   host_req,
  input  logic [2:0]             host_len,
  input  logic [8*MAX_BYTES-1:0] host_data,
  output logic                   host_grant,
  output logic                   host_done,
  input  logic                   player_req,
  input  logic [2:0]             player_len,
  input  logic [8*MAX_BYTES-1:0] player_data,
  output logic                   player_grant,
  output logic                   player_done,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic                   msg_sent,
  output logic                   error
);
  localparam int unsigned IdxW = $clog2(MAX_BYTES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                 state_q;
  logic [8*MAX_BYTES-1:0] data_q;
  logic [2:0]             len_q;
  logic [IdxW-1:0]        idx_q;
  logic [ToW-1:0]         to_q;
  logic                   owner_q;        // 1 = player owns the current message
  logic                   last_player_q;  // 1 = player was served last

  logic                   win_host, win_player, len_ok;
  logic [2:0]             sel_len;
  logic [8*MAX_BYTES-1:0] sel_data;
  logic [IdxW-1:0]        nxt_idx;
  logic [7:0]             nxt_byte;
  logic                   last_xfer, timeout_hit;
`ifdef MSG_CHECKSUM_EN
  logic [7:0]             csum_q, sel_csum;
`endif

  always_comb begin
    win_host   = host_req && (!player_req || last_player_q);
    win_player = player_req && !win_host;
    sel_len    = win_player ? player_len : host_len;
    sel_data   = win_player ? player_data : host_data;
    len_ok     = (sel_len != 3'd0) && (32'(sel_len) <= MAX_BYTES);
    nxt_idx    = idx_q + 1'b1;
    nxt_byte   = 8'h00;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (32'(nxt_idx) == i) nxt_byte = data_q[8*i +: 8];
    end
`ifdef MSG_CHECKSUM_EN
    // Index len addresses the trailing checksum byte.
    if (32'(nxt_idx) == 32'(len_q)) nxt_byte = csum_q;
    sel_csum = 8'h00;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < 32'(sel_len)) sel_csum = sel_csum ^ sel_data[8*i +: 8];
    end
    last_xfer = (32'(idx_q) == 32'(len_q));
`else
    last_xfer = (32'(idx_q) + 1 == 32'(len_q));
`endif
    timeout_hit = (32'(to_q) + 1 >= TIMEOUT_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q       <= StIdle;
      data_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      to_q          <= '0;
      owner_q       <= 1'b0;
      last_player_q <= 1'b1;
      host_grant    <= 1'b0;
      player_grant  <= 1'b0;
      host_done     <= 1'b0;
      player_done   <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= 8'h00;
      msg_sent      <= 1'b0;
      error         <= 1'b0;
`ifdef MSG_CHECKSUM_EN
      csum_q        <= 8'h00;
`endif
    end else begin
      host_done   <= 1'b0;
      player_done <= 1'b0;
      msg_sent    <= 1'b0;
      error       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_host || win_player) begin
            owner_q       <= win_player;
            last_player_q <= win_player;
            data_q        <= sel_data;
            len_q         <= sel_len;
            idx_q         <= '0;
            to_q          <= '0;
`ifdef MSG_CHECKSUM_EN
            csum_q        <= sel_csum;
`endif
            if (len_ok) begin
              state_q      <= StSend;
              host_grant   <= win_host;
              player_grant <= win_player;
              tx_valid     <= 1'b1;
              tx_data      <= sel_data[7:0];
            end else begin
              state_q     <= StDone;
              error       <= 1'b1;
              host_done   <= win_host;
              player_done <= win_player;
            end
          end
        end
        StSend: begin
          if (tx_ready) begin
            to_q <= '0;
            if (last_xfer) begin
              state_q      <= StDone;
              host_grant   <= 1'b0;
              player_grant <= 1'b0;
              tx_valid     <= 1'b0;
              host_done    <= !owner_q;
              player_done  <= owner_q;
              msg_sent     <= 1'b1;
            end else begin
              idx_q   <= nxt_idx;
              tx_data <= nxt_byte;
            end
          end else if (timeout_hit) begin
            to_q         <= ToW'(TIMEOUT_CYCLES);
            state_q      <= StDone;
            host_grant   <= 1'b0;
            player_grant <= 1'b0;
            tx_valid     <= 1'b0;
            host_done    <= !owner_q;
            player_done  <= owner_q;
            error        <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Self-checking bench for msg_tx_arbiter: directed table, hand-written corner sequences and
// randomized messages scored against a transaction-level model of arbitration and transfers.
module tb_msg_tx_arbiter;
  localparam int unsigned MB = 5;
  localparam int unsigned TO = 8;
  localparam logic [39:0] APPLE = 40'h45_4C_50_50_41;
  localparam logic [39:0] MOORE = 40'h45_52_4F_4F_4D;

  logic        clk = 1'b0;
  logic        Rst;
  logic        host_req, player_req, tx_ready;
  logic [2:0]  host_len, player_len;
  logic [39:0] host_data, player_data;
  logic        host_grant, host_done, player_grant, player_done;
  logic        tx_valid, msg_sent, error;
  logic [7:0]  tx_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  msg_tx_arbiter #(.MAX_BYTES(MB), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .Rst         (Rst),
    .host_req    (host_req),
    .host_len    (host_len),
    .host_data   (host_data),
    .host_grant  (host_grant),
    .host_done   (host_done),
    .player_req  (player_req),
    .player_len  (player_len),
    .player_data (player_data),
    .player_grant(player_grant),
    .player_done (player_done),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .msg_sent    (msg_sent),
    .error       (error)
  );

  typedef struct {
    logic        h, p;
    logic [2:0]  hl, pl;
    logic [39:0] hd, pd;
    logic        exp_player;
    logic        exp_err;
    int          mode;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".outs"},
        {25'd0, host_grant, host_done, player_grant, player_done, tx_valid, msg_sent, error}, 0);
  endtask

  // 0: always ready, 1: 70% ready, 2: 10% ready, 3: low for 3 cycles then ready, else never
  function automatic logic ready_for(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return $urandom_range(0, 9) < 7;
      2:       return $urandom_range(0, 9) == 0;
      3:       return n >= 3;
      default: return 1'b0;
    endcase
  endfunction

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_msg(input string name, input logic h, input logic p,
                         input logic [2:0] hl, input logic [2:0] pl,
                         input logic [39:0] hd, input logic [39:0] pd,
                         input logic exp_player, input logic exp_err, input int mode);
    logic [7:0]  q[$];
    logic [2:0]  len;
    logic [39:0] d;
    logic [7:0]  cs;
    int          low, n;
    bit          done_exp, success;
    len = exp_player ? pl : hl;
    d   = exp_player ? pd : hd;
    cs  = 8'h00;
    if (!exp_err) begin
      for (int i = 0; i < int'(len); i++) begin
        q.push_back(d[8*i +: 8]);
        cs = cs ^ d[8*i +: 8];
      end
`ifdef MSG_CHECKSUM_EN
      q.push_back(cs);
`endif
    end
    host_req    = h;
    player_req  = p;
    host_len    = hl;
    player_len  = pl;
    host_data   = hd;
    player_data = pd;
    tx_ready    = 1'($urandom());
    step();
    done_exp = exp_err;
    success  = 1'b0;
    low      = 0;
    n        = 0;
    while (!done_exp && n < 64) begin
      chk({name, ".grant"}, {30'd0, host_grant, player_grant}, exp_player ? 2 'b01 : 2'b10);
      chk({name, ".valid"}, {31'd0, tx_valid}, 1);
      chk({name, ".data"}, {24'd0, tx_data}, {24'd0, q[0]});
      chk({name, ".pulses"}, {28'd0, host_done, player_done, msg_sent, error}, 0);
      // Inputs change mid-message; the latched payload must not follow them.
      host_data   = {8'($urandom()), $urandom()};
      player_data = {8'($urandom()), $urandom()};
      tx_ready    = ready_for(mode, n);
      if (tx_ready) begin
        void'(q.pop_front());
        low = 0;
        if (q.size() == 0) begin
          done_exp = 1'b1;
          success  = 1'b1;
        end
      end else begin
        low++;
        if (low == int'(TO)) done_exp = 1'b1;
      end
      n++;
      step();
    end
    if (!done_exp) chk({name, ".budget"}, 0, 1);
    chk({name, ".done"},
        {25'd0, host_grant, player_grant, tx_valid, host_done, player_done, msg_sent, error},
        {25'd0, 3'b000, !exp_player, exp_player, success, !success});
    host_req   = 1'b0;
    player_req = 1'b0;
    step();
    chk_idle({name, ".after"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        last_player;
    logic        h, p, ep, ee;
    logic [2:0]  hl, pl;
    logic [39:0] hd, pd;

    tbl[0] = '{1'b1, 1'b1, 3'd5, 3'd5, APPLE, MOORE, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 3'd4, 3'd3, MOORE, APPLE, 1'b0, 1'b0, 1};
    tbl[2] = '{1'b1, 1'b1, 3'd2, 3'd5, APPLE, MOORE, 1'b1, 1'b0, 0};
    tbl[3] = '{1'b0, 1'b1, 3'd0, 3'd1, APPLE, 40'h50, 1'b1, 1'b0, 3};
    tbl[4] = '{1'b1, 1'b0, 3'd0, 3'd2, APPLE, MOORE, 1'b0, 1'b1, 0};
    tbl[5] = '{1'b1, 1'b0, 3'd6, 3'd2, APPLE, MOORE, 1'b0, 1'b1, 0};
    tbl[6] = '{1'b1, 1'b1, 3'd2, 3'd7, APPLE, MOORE, 1'b1, 1'b1, 0};
    tbl[7] = '{1'b1, 1'b1, 3'd3, 3'd2, MOORE, APPLE, 1'b0, 1'b0, 1};
    tbl[8] = '{1'b0, 1'b1, 3'd0, 3'd2, APPLE, MOORE, 1'b1, 1'b0, 4};

    Rst = 1'b1;
    host_req = 1'b0; player_req = 1'b0; tx_ready = 1'b0;
    host_len = '0; player_len = '0; host_data = '0; player_data = '0;
    step();
    step();
    Rst = 1'b0;
    chk_idle("reset");
    chk("reset.data", {24'd0, tx_data}, 0);
    step();
    chk_idle("reset.hold");

    run_msg("apple", 1'b1, 1'b0, 3'd5, 3'd0, APPLE, MOORE, 1'b0, 1'b0, 0);

    for (int i = 0; i < 9; i++) begin
      run_msg($sformatf("tbl%0d", i), tbl[i].h, tbl[i].p, tbl[i].hl, tbl[i].pl, tbl[i].hd,
              tbl[i].pd, tbl[i].exp_player, tbl[i].exp_err, tbl[i].mode);
    end

    // Reset in the middle of a host message after two bytes have gone out.
    host_req = 1'b1; host_len = 3'd5; host_data = MOORE; tx_ready = 1'b1;
    step();
    chk("moore.b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h4D});
    step();
    chk("moore.b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h4F});
    step();
    chk("moore.b2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h4F});
    Rst = 1'b1;
    host_req = 1'b0;
    step();
    chk_idle("rst_mid");
    chk("rst_mid.data", {24'd0, tx_data}, 0);
    Rst = 1'b0;
    step();
    chk_idle("rst_mid.nodone");
    run_msg("tie_after_rst", 1'b1, 1'b1, 3'd2, 3'd2, APPLE, MOORE, 1'b0, 1'b0, 0);

    // Randomized messages; model tracks who was served last.
    last_player = 1'b0;
    for (int k = 0; k < 200; k++) begin
      h  = 1'($urandom());
      p  = 1'($urandom());
      if (!h && !p) h = 1'b1;
      hl = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 5)) : 3'($urandom_range(0, 7));
      pl = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(1, 5)) : 3'($urandom_range(0, 7));
      hd = {8'($urandom()), $urandom()};
      pd = {8'($urandom()), $urandom()};
      ep = (h && p) ? !last_player : p;
      ee = ep ? (pl == 3'd0 || int'(pl) > int'(MB)) : (hl == 3'd0 || int'(hl) > int'(MB));
      last_player = ep;
      run_msg($sformatf("rnd%0d", k), h, p, hl, pl, hd, pd, ep, ee, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
